// File: rtl/axis_matmul_nxn.sv
// rtl/axis_matmul_nxn.sv - streaming NxN unsigned matrix multiplier using outer-product accumulation
//
// Purpose:
//   Input beat k carries column k of A and row k of B. Every accepted beat adds
//   the outer product a x b into an NxN accumulator. When the frame ends, C = A x B
//   is sent out one row per output beat, and the block then returns to IDLE.
//
// Ports:
//   clk             single clock, rising edge
//   rst             asynchronous active-low reset
//   s_axis_tvalid   input beat valid
//   s_axis_tdata    a_i at [i*DW +: DW], b_j at [(N+j)*DW +: DW]
//   s_axis_tlast    final input beat of a matrix pair
//   s_axis_tready   high in IDLE/ACCUM, low while draining and during reset
//   m_axis_tvalid   output row valid
//   m_axis_tdata    C[r][j] at [j*AW +: AW]
//   m_axis_tlast    high on row N-1 only
//   m_axis_tready   downstream ready
//   frame_err       sticky; set by early tlast or a missing tlast; cleared only by reset
//
// Build option:
//   AXIS_MATMUL_SAT_EN  defined   -> each accumulate saturates at 2^AW-1
//                       undefined -> each accumulate wraps modulo 2^AW

module axis_matmul_nxn #(
   parameter int N  = 2,
   parameter int DW = 4,
   parameter int AW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_axis_tvalid,
   input  logic [2*N*DW-1:0] s_axis_tdata,
   input  logic              s_axis_tlast,
   output logic              s_axis_tready,
   output logic              m_axis_tvalid,
   output logic [N*AW-1:0]   m_axis_tdata,
   output logic              m_axis_tlast,
   input  logic              m_axis_tready,
   output logic              frame_err
);

   localparam int KW = $clog2(N);
   localparam int PW = 2 * DW;
   // Sum width is wide enough to hold the accumulator plus a full product with carry.
   localparam int SW = ((PW > AW) ? PW : AW) + 1;
   localparam logic [KW-1:0] LAST_IDX = KW'(N - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

   state_t          state;
   logic [KW-1:0]   k;
   logic [KW-1:0]   r;
   logic [KW-1:0]   r_inc;
   logic [AW-1:0]   acc     [N][N];
   logic [AW-1:0]   acc_nxt [N][N];
   logic [N*AW-1:0] row_first;
   logic [N*AW-1:0] row_next;
   logic            s_hs;
   logic            m_hs;
   logic            frame_end;
   logic            frame_bad;

   // Add one full-width product into one accumulator element.
   function automatic logic [AW-1:0] acc_add(input logic [AW-1:0] a, input logic [PW-1:0] p);
`ifdef AXIS_MATMUL_SAT_EN
      logic [SW-1:0] s;
      s = SW'(a) + SW'(p);
      if (s[SW-1:AW] != '0) begin
         return '1;
      end
      return s[AW-1:0];
`else
      return a + AW'(p);
`endif
   endfunction

   assign s_hs = s_axis_tvalid & s_axis_tready;
   assign m_hs = m_axis_tvalid & m_axis_tready;

   // The frame closes on tlast or on the Nth beat, whichever comes first.
   // A mismatch between those two conditions is a framing error.
   assign frame_end = s_hs & (s_axis_tlast | (k == LAST_IDX));
   assign frame_bad = s_hs & (s_axis_tlast ^ (k == LAST_IDX));

   assign r_inc = (r == LAST_IDX) ? '0 : r + KW'(1);

   // Accumulator contents after the current beat is accepted.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            acc_nxt[i][j] = acc[i][j];
            if (s_hs) begin
               acc_nxt[i][j] = acc_add(acc[i][j],
                                       PW'(s_axis_tdata[i*DW +: DW]) *
                                       PW'(s_axis_tdata[(N+j)*DW +: DW]));
            end
         end
      end
   end

   // row_first includes the frame-ending beat, so row 0 can be registered on the
   // same edge that enters DRAIN. This gives the one-cycle output latency.
   always_comb begin
      row_first = '0;
      row_next  = '0;
      for (int j = 0; j < N; j++) begin
         row_first[j*AW +: AW] = acc_nxt[0][j];
         row_next[j*AW +: AW]  = acc[r_inc][j];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         k             <= '0;
         r             <= '0;
         frame_err     <= 1'b0;
         s_axis_tready <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               acc[i][j] <= '0;
            end
         end
      end else begin
         case (state)
            IDLE, ACCUM: begin
               s_axis_tready <= 1'b1;
               if (s_hs) begin
                  for (int i = 0; i < N; i++) begin
                     for (int j = 0; j < N; j++) begin
                        acc[i][j] <= acc_nxt[i][j];
                     end
                  end
                  if (frame_bad) begin
                     frame_err <= 1'b1;
                  end
                  if (frame_end) begin
                     // Columns that were not sent stay zero in acc.
                     state         <= DRAIN;
                     k             <= '0;
                     r             <= '0;
                     s_axis_tready <= 1'b0;
                     m_axis_tvalid <= 1'b1;
                     m_axis_tdata  <= row_first;
                     m_axis_tlast  <= 1'b0;
                  end else begin
                     state <= ACCUM;
                     k     <= k + KW'(1);
                  end
               end
            end

            DRAIN: begin
               // Data and last are registered, so they hold while the sink stalls.
               if (m_hs) begin
                  if (r == LAST_IDX) begin
                     state         <= IDLE;
                     k             <= '0;
                     r             <= '0;
                     s_axis_tready <= 1'b1;
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     m_axis_tdata  <= '0;
                     for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                           acc[i][j] <= '0;
                        end
                     end
                  end else begin
                     r            <= r_inc;
                     m_axis_tdata <= row_next;
                     m_axis_tlast <= (r_inc == LAST_IDX);
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/axis_matmul_nxn.md
AXIS_MATMUL_NXN -- requirements
Module: axis_matmul_nxn

Interface
REQ-001 SHALL have parameter N, default 2: matrix dimension, legal 2..8.
REQ-002 SHALL have parameter DW, default 4: unsigned operand width, legal 2..16.
REQ-003 SHALL have parameter AW, default 16: accumulator/result element width, legal DW..32.
REQ-004 SHALL have port clk  in  1: single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port s_axis_tvalid  in  1: input beat valid.
REQ-007 SHALL have port s_axis_tdata  in  2*N*DW: a_i at [i*DW +: DW], b_j at [(N+j)*DW +: DW].
REQ-008 SHALL have port s_axis_tlast  in  1: marks final input beat of a matrix pair.
REQ-009 SHALL have port s_axis_tready  out  1: input beat accepted when valid&ready.
REQ-010 SHALL have port m_axis_tvalid  out  1: output row valid.
REQ-011 SHALL have port m_axis_tdata  out  N*AW: C[r][j] at [j*AW +: AW].
REQ-012 SHALL have port m_axis_tlast  out  1: high on row N-1 only.
REQ-013 SHALL have port m_axis_tready  in  1: downstream ready.
REQ-014 SHALL have port frame_err  out  1: sticky framing-error flag.

Function
REQ-015 SHALL compute C = A x B by outer-product accumulation: input beat k carries column k of A (a_i) and row k of B (b_j); on acceptance acc[i][j] += a_i*b_j for all i,j.
REQ-016 SHALL implement states IDLE, ACCUM, DRAIN; reset state IDLE.
REQ-017 IDLE: s_axis_tready=1, acc all zero, beat counter k=0; first accepted beat moves to ACCUM (or straight to DRAIN if it ends the frame).
REQ-018 ACCUM: s_axis_tready=1; each accepted beat increments k.
REQ-019 Frame ends on the accepted beat with tlast=1 or with k=N-1, whichever comes first; next cycle state=DRAIN, row counter r=0.
REQ-020 Early tlast (k<N-1): remaining columns treated as zero; frame_err set.
REQ-021 Beat k=N-1 without tlast: frame ends anyway; frame_err set.
REQ-022 DRAIN: s_axis_tready=0; m_axis_tvalid=1; m_axis_tdata=row r of acc; m_axis_tlast=(r==N-1).
REQ-023 Output data/last SHALL remain stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 On m handshake r increments; handshake at r=N-1 clears acc, k, r and returns to IDLE next cycle.
REQ-025 Latency: m_axis_tvalid asserts exactly one cycle after the frame-ending input handshake; back-to-back frames separated by one IDLE cycle minimum.
REQ-026 Products SHALL be full width 2*DW, zero-extended to AW before accumulation; overflow behaviour per REQ-031.
REQ-027 frame_err SHALL be cleared only by reset.

Reset
REQ-028 Reset asserted (rst=0) SHALL immediately force: state IDLE, acc=0, k=0, r=0, frame_err=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0 during reset.
REQ-029 Reset mid-frame or mid-drain SHALL discard partial results; no row emitted after release until a new frame completes.
REQ-030 s_axis_tready SHALL rise on the first clk edge after rst deasserts.

Configuration
REQ-031 Macro AXIS_MATMUL_SAT_EN: defined -> each accumulate saturates at 2^AW-1; undefined -> accumulate wraps modulo 2^AW.
REQ-032 Interface and timing SHALL be identical with or without AXIS_MATMUL_SAT_EN.

Verification (N=2, DW=4 unless stated)
REQ-033 Beats {a=(1,3),b=(5,6)}, {a=(2,4),b=(7,8),tlast} -> rows {22,19} then {50,43} (C[r][1],C[r][0]), tlast on row 1, frame_err=0.
REQ-034 Same frame, m_axis_tready low 5 cycles on row 0 -> data held {22,19}, s_axis_tready=0 throughout drain.
REQ-035 AW=8, all operands 15, 2 beats -> C elements 255 with AXIS_MATMUL_SAT_EN, 194 without.
REQ-036 tlast on beat 0 {a=(1,3),b=(5,6)} -> rows {6,5},{18,15}, frame_err=1 and stays 1 across next clean frame.
REQ-037 rst pulsed low after beat 0 -> outputs zero immediately; next full frame of REQ-033 yields REQ-033 results.
REQ-038 N=4, A=identity, B=rows (1,2,3,4)x4 -> four output rows equal (4,3,2,1) packed, tlast on row 3.
